// File: rtl/cdc_2phase_dst_fifo_pkg.sv
// Shared defaults and sizing helpers for the 2-phase CDC destination buffer.
package cdc_2phase_dst_fifo_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH  = 34;
  localparam int unsigned DEFAULT_SYNC_STAGES = 2;
  localparam int unsigned DEFAULT_DEPTH       = 2;

  // A single-entry buffer still needs a one-bit pointer to keep the vector legal.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/cdc_2phase_dst_fifo_sync.sv
// Multi-flop level synchroniser for the incoming toggle request.
module cdc_2phase_dst_fifo_sync
  import cdc_2phase_dst_fifo_pkg::*;
#(
  parameter int unsigned STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  (* async_reg = "true", dont_touch = "true" *) logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  assign sync_d[0] = d_i;

  for (genvar gi = 1; gi < STAGES; gi++) begin : g_chain
    assign sync_d[gi] = sync_q[gi-1];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_2phase_dst_fifo.sv
// Destination half of a 2-phase req/ack crossing with a local receive buffer,
// so the ack returns on capture rather than on downstream consumption.
module cdc_2phase_dst_fifo
  import cdc_2phase_dst_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter int unsigned DEPTH       = DEFAULT_DEPTH
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         clear_i,
  output logic [DATA_WIDTH-1:0]        data_o,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic [$clog2(DEPTH+1)-1:0]   level_o,
  input  logic                         async_req_i,
  output logic                         async_ack_o,
  input  logic [DATA_WIDTH-1:0]        async_data_i
);

  localparam int unsigned PTR_W = ptr_width(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic                 req_synced;
  logic                 req_synced_q1;
  (* async_reg = "true", dont_touch = "true" *) logic ack_q;
  logic                 ack_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 valid_q;
  logic                 pending;
  logic                 push;
  logic                 pop;

  (* dont_touch = "true" *) logic [DATA_WIDTH-1:0] mem [DEPTH];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  cdc_2phase_dst_fifo_sync #(
    .STAGES (SYNC_STAGES)
  ) u_req_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (async_req_i),
    .q_o    (req_synced)
  );

  // A full buffer still accepts when the head leaves on the same edge.
  assign pending = (req_synced_q1 != ack_q);
  assign pop     = valid_q && ready_i && !clear_i;
  assign push    = pending && !clear_i && ((count_q < CNT_W'(DEPTH)) || pop);

  always_comb begin
    ack_d    = ack_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      ack_d    = 1'b0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        ack_d    = ~ack_q;
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_synced_q1 <= 1'b0;
      ack_q         <= 1'b0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      valid_q       <= 1'b0;
    end else begin
      req_synced_q1 <= req_synced;
      ack_q         <= ack_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      valid_q       <= (count_d != '0);
    end
  end

  // Storage carries no reset; contents are only observed while valid_o is high.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr_q] <= async_data_i;
    end
  end

  assign data_o      = mem[rd_ptr_q];
  assign valid_o     = valid_q;
  assign level_o     = count_q;
  assign async_ack_o = ack_q;

endmodule

// File: tb/tb_cdc_2phase_dst_fifo.sv
// Directed and scoreboard checks for the 2-phase CDC destination buffer.
module tb_cdc_2phase_dst_fifo;

  localparam int DW = 34;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          clear, ready, req;
  logic [DW-1:0] din, dout;
  logic          valid, ack;
  logic [1:0]    level;

  logic          clear1, ready1, req1;
  logic [7:0]    din1, dout1;
  logic          valid1, ack1;
  logic [0:0]    level1;

  int passed = 0;
  int total  = 0;

  cdc_2phase_dst_fifo #(.DATA_WIDTH(DW), .SYNC_STAGES(2), .DEPTH(2)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .data_o(dout), .valid_o(valid),
    .ready_i(ready), .level_o(level), .async_req_i(req), .async_ack_o(ack),
    .async_data_i(din)
  );

  cdc_2phase_dst_fifo #(.DATA_WIDTH(8), .SYNC_STAGES(2), .DEPTH(1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear1), .data_o(dout1), .valid_o(valid1),
    .ready_i(ready1), .level_o(level1), .async_req_i(req1), .async_ack_o(ack1),
    .async_data_i(din1)
  );

  typedef struct {
    logic          tog;
    logic [DW-1:0] data;
    logic          rdy;
    int            cyc;
    logic          exp_valid;
    logic [1:0]    exp_level;
    logic          exp_ack;
    logic          chk_data;
    logic [DW-1:0] exp_data;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(input logic tog, input logic [DW-1:0] data, input logic rdy,
                              input int cyc, input logic ev, input logic [1:0] el,
                              input logic ea, input logic cd, input logic [DW-1:0] ed);
    vec_t v;
    v.tog = tog; v.data = data; v.rdy = rdy; v.cyc = cyc;
    v.exp_valid = ev; v.exp_level = el; v.exp_ack = ea; v.chk_data = cd; v.exp_data = ed;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [7:0] words[100];
  int recvd;
  int sent;

  initial begin
    rst_n = 1'b0; clear = 1'b0; ready = 1'b0; req = 1'b0; din = '0;
    clear1 = 1'b0; ready1 = 1'b0; req1 = 1'b0; din1 = '0;

    // Reset state and first-word latency
    tick(3);
    check("rst_valid", valid, 0);
    check("rst_level", level, 0);
    check("rst_ack", ack, 0);
    rst_n = 1'b1;
    tick(1);
    check("post_rst_valid", valid, 0);
    check("post_rst_ack", ack, 0);
    req = 1'b1; din = 34'h2_DEAD_BEEF;
    for (int i = 1; i <= 4; i++) begin
      tick(1);
      if (i < 4) begin
        check($sformatf("lat_valid_c%0d", i), valid, 0);
        check($sformatf("lat_ack_c%0d", i), ack, 0);
      end else begin
        check("lat_valid", valid, 1);
        check("lat_ack", ack, 1);
        check("lat_data", dout, 34'h2_DEAD_BEEF);
        check("lat_level", level, 1);
      end
    end
    ready = 1'b1; tick(1); ready = 1'b0;
    check("lat_pop_level", level, 0);
    check("lat_pop_valid", valid, 0);

    // Buffering, stall when full, same-edge push/pop, drain
    vecs[0]  = mk(1, 34'h1,  0, 4, 1, 2'd1, 0, 1, 34'h1);
    vecs[1]  = mk(1, 34'h2,  0, 4, 1, 2'd2, 1, 1, 34'h1);
    vecs[2]  = mk(1, 34'h3,  0, 4, 1, 2'd2, 1, 1, 34'h1);
    vecs[3]  = mk(0, 34'h0,  0, 2, 1, 2'd2, 1, 1, 34'h1);
    vecs[4]  = mk(0, 34'h0,  1, 1, 1, 2'd2, 0, 1, 34'h2);
    vecs[5]  = mk(0, 34'h0,  1, 1, 1, 2'd1, 0, 1, 34'h3);
    vecs[6]  = mk(0, 34'h0,  1, 1, 0, 2'd0, 0, 0, 34'h0);
    vecs[7]  = mk(0, 34'h0,  0, 1, 0, 2'd0, 0, 0, 34'h0);
    vecs[8]  = mk(1, 34'h11, 0, 4, 1, 2'd1, 1, 1, 34'h11);
    vecs[9]  = mk(1, 34'h22, 0, 4, 1, 2'd2, 0, 1, 34'h11);
    vecs[10] = mk(1, 34'h33, 0, 4, 1, 2'd2, 0, 1, 34'h11);
    vecs[11] = mk(0, 34'h0,  1, 1, 1, 2'd2, 1, 1, 34'h22);
    vecs[12] = mk(0, 34'h0,  0, 2, 1, 2'd2, 1, 1, 34'h22);
    vecs[13] = mk(0, 34'h0,  1, 1, 1, 2'd1, 1, 1, 34'h33);
    vecs[14] = mk(0, 34'h0,  1, 1, 0, 2'd0, 1, 0, 34'h0);
    vecs[15] = mk(0, 34'h0,  0, 1, 0, 2'd0, 1, 0, 34'h0);
    for (int i = 0; i < 16; i++) begin
      if (vecs[i].tog) begin
        req = ~req;
        din = vecs[i].data;
      end
      ready = vecs[i].rdy;
      tick(vecs[i].cyc);
      check($sformatf("vec%0d_valid", i), valid, vecs[i].exp_valid);
      check($sformatf("vec%0d_level", i), level, vecs[i].exp_level);
      check($sformatf("vec%0d_ack", i), ack, vecs[i].exp_ack);
      if (vecs[i].chk_data) check($sformatf("vec%0d_data", i), dout, vecs[i].exp_data);
    end
    ready = 1'b0;

    // Clear with two words held and ack_q=1
    req = 1'b0; din = 34'h0_000A_AAAA; tick(4);
    req = 1'b1; din = 34'h1_0000_BBBB; tick(4);
    check("clr_pre_level", level, 2);
    check("clr_pre_ack", ack, 1);
    clear = 1'b1; ready = 1'b1; req = 1'b0;
    tick(1);
    check("clr_level", level, 0);
    check("clr_valid", valid, 0);
    check("clr_ack", ack, 0);
    ready = 1'b0;
    tick(3);
    clear = 1'b0;
    tick(2);
    check("clr_settled_level", level, 0);
    check("clr_settled_ack", ack, 0);
    req = 1'b1; din = 34'h3_0000_000C; tick(4);
    check("clr_new_valid", valid, 1);
    check("clr_new_data", dout, 34'h3_0000_000C);
    check("clr_new_ack", ack, 1);
    ready = 1'b1; tick(1); ready = 1'b0;
    check("clr_new_pop_level", level, 0);

    // Asynchronous reset with a request in flight
    req = 1'b0; din = 34'h0_1234_5678; tick(2);
    check("arst_pre_ack", ack, 1);
    rst_n = 1'b0; #1;
    check("arst_valid", valid, 0);
    check("arst_level", level, 0);
    check("arst_ack", ack, 0);
    tick(2);
    rst_n = 1'b1;
    tick(6);
    check("arst_after_valid", valid, 0);
    check("arst_after_level", level, 0);
    check("arst_after_ack", ack, 0);

    // DEPTH=1 scoreboard with random consumer stalls
    for (int i = 0; i < 100; i++) words[i] = 8'($urandom);
    recvd = 0;
    sent  = 0;
    fork
      begin
        for (int i = 0; i < 100; i++) begin
          int guard;
          guard = 0;
          din1 = words[i];
          req1 = ~req1;
          do begin
            @(posedge clk); #1;
            guard++;
          end while (ack1 !== req1 && guard < 200);
          if (ack1 !== req1) break;
          sent++;
        end
      end
      begin
        for (int c = 0; c < 6000 && recvd < 100; c++) begin
          @(negedge clk);
          ready1 = 1'($urandom_range(0, 1));
          #1;
          check("d1_valid_vs_level", valid1, level1);
          if (valid1 && ready1) begin
            check($sformatf("d1_word%0d", recvd), dout1, words[recvd]);
            recvd++;
          end
        end
        ready1 = 1'b0;
      end
    join
    check("d1_sent", sent, 100);
    check("d1_received", recvd, 100);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
